// File: rtl/crc32_serial_engine_if.sv
// Purpose : byte-stream handshake between a CRC producer (seal/CPU ownership
//           mux) and the bit-serial CRC-32 engine.
// Signals : crc_init/crc_data/crc_dv       producer -> engine
//           crc_ready/crc_busy/crc_done    engine -> producer (flow/status)
//           crc_value/crc_byte_count/crc_ovf engine -> producer (result)
// Modports: master = producer side, slave = engine side.
interface crc32_serial_engine_if #(
    parameter int CNT_W = 16
);
    logic             crc_init;
    logic [7:0]       crc_data;
    logic             crc_dv;
    logic             crc_ready;
    logic             crc_busy;
    logic             crc_done;
    logic [31:0]      crc_value;
    logic [CNT_W-1:0] crc_byte_count;
    logic             crc_ovf;

    modport master (
        output crc_init, crc_data, crc_dv,
        input  crc_ready, crc_busy, crc_done, crc_value, crc_byte_count, crc_ovf
    );

    modport slave (
        input  crc_init, crc_data, crc_dv,
        output crc_ready, crc_busy, crc_done, crc_value, crc_byte_count, crc_ovf
    );
endinterface

// File: rtl/crc32_serial_engine.sv
// Purpose : bit-serial CRC-32 (IEEE 802.3, reflected). One LFSR shift per
//           clock, bytes absorbed LSB first, with a one-byte holding register
//           so a producer can issue back-to-back bytes.
// Ports   : clk  - system clock, all state on rising edge
//           rst  - asynchronous active-high reset
//           bus  - crc32_serial_engine_if.slave:
//                  crc_init (restart), crc_data/crc_dv (byte in),
//                  crc_ready (hold empty), crc_busy, crc_done (byte absorbed),
//                  crc_value (lfsr ^ XOROUT), crc_byte_count (saturating),
//                  crc_ovf (sticky, byte dropped while not ready)
module crc32_serial_engine #(
    parameter logic [31:0] POLY_REFL = 32'hEDB88320,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT    = 32'hFFFFFFFF,
    parameter int          CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    crc32_serial_engine_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [31:0]      lfsr;
    logic [7:0]       sreg;
    logic [2:0]       bitcnt;
    logic [7:0]       hold;
    logic             hold_v;
    logic             done_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_r;

    logic             last_shift;
    logic             accept;
    logic             fb;
    logic [31:0]      lfsr_next;

    always_comb begin
        last_shift = (state == ST_SHIFT) && (bitcnt == 3'd7);
        // The last shift drains hold into sreg, so a byte offered in that
        // cycle is taken even though hold is currently full.
        accept     = bus.crc_dv && (!hold_v || last_shift);
        fb         = lfsr[0] ^ sreg[0];
        lfsr_next  = {1'b0, lfsr[31:1]} ^ (fb ? POLY_REFL : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            lfsr    <= INIT;
            sreg    <= '0;
            bitcnt  <= '0;
            hold    <= '0;
            hold_v  <= 1'b0;
            done_r  <= 1'b0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (bus.crc_init) begin
            // Restart; a byte offered alongside init opens the new message.
            lfsr    <= INIT;
            hold_v  <= 1'b0;
            done_r  <= 1'b0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            bitcnt  <= '0;
            if (bus.crc_dv) begin
                sreg  <= bus.crc_data;
                state <= ST_SHIFT;
            end else begin
                state <= ST_IDLE;
            end
        end else begin
            done_r <= 1'b0;
            if (bus.crc_dv && !accept)
                ovf_r <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (bus.crc_dv) begin
                        sreg   <= bus.crc_data;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                default: begin
                    lfsr   <= lfsr_next;
                    sreg   <= sreg >> 1;
                    bitcnt <= bitcnt + 3'd1;
                    if (last_shift) begin
                        done_r <= 1'b1;
                        if (count_r != '1)
                            count_r <= count_r + CNT_W'(1);
                        if (hold_v) begin
                            sreg   <= hold;
                            bitcnt <= '0;
                            if (bus.crc_dv)
                                hold <= bus.crc_data;
                            else
                                hold_v <= 1'b0;
                        end else if (bus.crc_dv) begin
                            sreg   <= bus.crc_data;
                            bitcnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (accept) begin
                        hold   <= bus.crc_data;
                        hold_v <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.crc_ready      = !hold_v;
    assign bus.crc_busy       = (state == ST_SHIFT) || hold_v;
    assign bus.crc_done       = done_r;
    assign bus.crc_value      = lfsr ^ XOROUT;
    assign bus.crc_byte_count = count_r;
    assign bus.crc_ovf        = ovf_r;
endmodule

// File: tb/tb_crc32_serial_engine.sv
module tb_crc32_serial_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc32_serial_engine_if #(.CNT_W(16)) bus ();

    crc32_serial_engine #(
        .POLY_REFL(32'hEDB88320),
        .INIT     (32'hFFFFFFFF),
        .XOROUT   (32'hFFFFFFFF),
        .CNT_W    (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic [15:0] cnt;
        bit          chk;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned done_seen = 0;
    int unsigned done_cyc  = 0;
    int unsigned acc_cyc   = 0;
    logic [15:0] exp_count = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.crc_done === 1'b1) begin
                done_seen++;
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    check("done_without_expectation", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_count", 32'(bus.crc_byte_count), 32'(e.cnt));
                    if (e.chk) check("done_value", bus.crc_value, e.val);
                end
            end
        end
    end

    task automatic push_exp(input bit chk, input logic [31:0] v);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.cnt = exp_count;
        e.chk = chk;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        @(negedge clk);
        while (bus.crc_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.crc_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (bus.crc_busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.crc_busy !== 1'b0) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit chk, input logic [31:0] v);
        wait_ready();
        acc_cyc = cyc;
        bus.crc_data = d;
        bus.crc_dv   = 1'b1;
        @(posedge clk);
        push_exp(chk, v);
        #1 bus.crc_dv = 1'b0;
    endtask

    task automatic do_init();
        @(negedge clk);
        bus.crc_init = 1'b1;
        @(posedge clk);
        sb.delete();
        exp_count = '0;
        #1 bus.crc_init = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.crc_ready), 32'd1);
        check({tag, "_busy"},  32'(bus.crc_busy),  32'd0);
        check({tag, "_done"},  32'(bus.crc_done),  32'd0);
        check({tag, "_value"}, bus.crc_value,      32'h0);
        check({tag, "_count"}, 32'(bus.crc_byte_count), 32'd0);
        check({tag, "_ovf"},   32'(bus.crc_ovf),   32'd0);
    endtask

    initial begin
        string s;
        int unsigned seen0;
        int unsigned c0;
        int unsigned n;

        bus.crc_init = 1'b0;
        bus.crc_data = '0;
        bus.crc_dv   = 1'b0;
        s = "123456789";

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1: check value "123456789"
        do_init();
        for (int i = 0; i < 9; i++)
            send_byte(s[i], i == 8, 32'hCBF43926);
        wait_idle();
        check("t1_value", bus.crc_value, 32'hCBF43926);
        check("t1_count", 32'(bus.crc_byte_count), 32'd9);
        check("t1_ovf",   32'(bus.crc_ovf), 32'd0);

        // T2: empty message, then single zero byte with latency
        do_init();
        @(negedge clk);
        check("t2_empty_value", bus.crc_value, 32'h0);
        check("t2_empty_busy",  32'(bus.crc_busy), 32'd0);
        seen0 = done_seen;
        send_byte(8'h00, 1'b1, 32'hD202EF8D);
        repeat (14) @(negedge clk);
        check("t2_done_once", done_seen - seen0, 32'd1);
        check("t2_latency", done_cyc - (acc_cyc + 1), 32'd8);
        check("t2_value", bus.crc_value, 32'hD202EF8D);

        // T3: dv held three cycles from idle
        do_init();
        @(negedge clk);
        c0 = cyc;
        bus.crc_data = 8'hA5; bus.crc_dv = 1'b1;
        @(posedge clk); push_exp(1'b0, '0);
        @(negedge clk);
        check("t3_ready_2nd", 32'(bus.crc_ready), 32'd1);
        bus.crc_data = 8'h5A;
        @(posedge clk); push_exp(1'b0, '0);
        @(negedge clk);
        check("t3_ready_3rd", 32'(bus.crc_ready), 32'd0);
        bus.crc_data = 8'hFF;
        @(posedge clk);
        #1 bus.crc_dv = 1'b0;
        @(negedge clk);
        check("t3_ovf", 32'(bus.crc_ovf), 32'd1);
        n = 0;
        while (bus.crc_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("t3_ready_return_cycle", cyc - c0, 32'd9);
        wait_idle();
        check("t3_count", 32'(bus.crc_byte_count), 32'd2);
        check("t3_ovf_sticky", 32'(bus.crc_ovf), 32'd1);

        // T4: init during the 3rd shift of byte 2
        do_init();
        send_byte(8'h11, 1'b0, '0);
        send_byte(8'h22, 1'b0, '0);
        send_byte(8'h33, 1'b0, '0);   // accepted on byte 2's first shift
        @(negedge clk);
        check("t4_ready_low", 32'(bus.crc_ready), 32'd0);
        bus.crc_data = 8'h44; bus.crc_dv = 1'b1;   // dropped on 2nd shift
        @(negedge clk);
        bus.crc_dv = 1'b0;
        check("t4_ovf_set", 32'(bus.crc_ovf), 32'd1);
        bus.crc_init = 1'b1;                       // taken on 3rd shift
        @(posedge clk);
        sb.delete();
        exp_count = '0;
        #1 bus.crc_init = 1'b0;
        @(negedge clk);
        check_reset_outputs("t4");

        // T5: init with first byte, then the rest of "123456789"
        @(negedge clk);
        bus.crc_init = 1'b1; bus.crc_dv = 1'b1; bus.crc_data = 8'h31;
        @(posedge clk);
        sb.delete();
        exp_count = '0;
        push_exp(1'b0, '0);
        #1 begin bus.crc_init = 1'b0; bus.crc_dv = 1'b0; end
        for (int i = 1; i < 9; i++)
            send_byte(s[i], i == 8, 32'hCBF43926);
        wait_idle();
        check("t5_value", bus.crc_value, 32'hCBF43926);
        check("t5_count", 32'(bus.crc_byte_count), 32'd9);

        // Asynchronous reset in the middle of a shift
        send_byte(8'h55, 1'b0, '0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        sb.delete();
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
